// File: rtl/uart_cmd_host.sv
// Host side of the UART calculator link: sends {A,B,op} as even-parity
// frames, retries rejected bytes and checks the returned result frame.
module uart_cmd_host #(
  parameter int BIT_CYCLES   = 868,
  parameter int GAP_CYCLES   = 16,
  parameter int MAX_RETRY    = 3,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic       clk,
  input  logic       res,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [7:0] cmd_op,
  output logic       cmd_ready,
  output logic       tx_line,
  input  logic       peer_rx_rdy,
  input  logic       peer_rx_ok,
  input  logic       rx_line,
  output logic       peer_tx_en,
  output logic       peer_flag,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_err
);

  localparam int CMAX = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TO   = TIMEOUT_BITS * BIT_CYCLES;
  localparam int TW   = $clog2(TO + 1);
  localparam int RW   = $clog2(MAX_RETRY + 2);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO - 1);
  localparam logic [RW-1:0] RMAX      = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, TX_WAIT, TX_FRAME, TX_GAP, RX_WAIT, RX_FRAME, DONE
  } state_t;

  state_t        state;
  logic [7:0]    a, b, op;
  logic [1:0]    byte_idx;
  logic [RW-1:0] retry;
  logic [CW-1:0] cyc;
  logic [3:0]    bit_cnt;
  logic [10:0]   frame;
  logic [TW-1:0] tmr;
  logic          rx_s1, rx_s2;
  logic [7:0]    sh;
  logic          rx_par;
  logic [1:0]    send_idx;
  logic [7:0]    next_byte;
  logic          rx_good;

  function automatic logic [10:0] mk_frame(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  // Byte to launch at the end of a gap: the next one if accepted, else again.
  assign send_idx = peer_rx_ok ? byte_idx + 2'd1 : byte_idx;

  always_comb begin
    next_byte = op;
    unique case (send_idx)
      2'd0:    next_byte = a;
      2'd1:    next_byte = b;
      default: next_byte = op;
    endcase
  end

  assign rx_good = (rx_par == ^sh) & rx_s2;

  always_ff @(posedge clk) begin
    if (res) begin
      state      <= IDLE;
      tx_line    <= 1'b1;
      cmd_ready  <= 1'b1;
      peer_tx_en <= 1'b0;
      peer_flag  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_err    <= 2'd0;
      a          <= 8'h00;
      b          <= 8'h00;
      op         <= 8'h00;
      byte_idx   <= 2'd0;
      retry      <= '0;
      cyc        <= '0;
      bit_cnt    <= 4'd0;
      frame      <= '1;
      tmr        <= '0;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      sh         <= 8'h00;
      rx_par     <= 1'b0;
    end else begin
      rx_s1     <= rx_line;
      rx_s2     <= rx_s1;
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            a         <= cmd_a;
            b         <= cmd_b;
            op        <= cmd_op;
            byte_idx  <= 2'd0;
            retry     <= '0;
            cmd_ready <= 1'b0;
            state     <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (peer_rx_rdy) begin
            frame   <= mk_frame(a);
            tx_line <= 1'b0;
            cyc     <= '0;
            bit_cnt <= 4'd0;
            state   <= TX_FRAME;
          end
        end
        TX_FRAME: begin
          if (cyc == BIT_LAST) begin
            cyc <= '0;
            if (bit_cnt == 4'd10) begin
              state <= TX_GAP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              tx_line <= frame[1];
              frame   <= {1'b1, frame[10:1]};
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        TX_GAP: begin
          if (cyc != GAP_LAST) begin
            cyc <= cyc + 1'b1;
          end else if (peer_rx_rdy) begin
            if (peer_rx_ok && byte_idx == 2'd2) begin
              retry      <= '0;
              tmr        <= '0;
              peer_tx_en <= 1'b1;
              state      <= RX_WAIT;
            end else if (!peer_rx_ok && retry == RMAX) begin
              rsp_valid  <= 1'b1;
              rsp_err    <= 2'd1;
              rsp_data   <= 8'h00;
              peer_tx_en <= 1'b0;
              state      <= DONE;
            end else begin
              if (peer_rx_ok) begin
                byte_idx <= byte_idx + 2'd1;
                retry    <= '0;
              end else begin
                retry <= retry + 1'b1;
              end
              frame   <= mk_frame(next_byte);
              tx_line <= 1'b0;
              cyc     <= '0;
              bit_cnt <= 4'd0;
              state   <= TX_FRAME;
            end
          end
        end
        RX_WAIT: begin
          if (!rx_s2) begin
            cyc     <= '0;
            bit_cnt <= 4'd0;
            state   <= RX_FRAME;
          end else if (tmr == TO_LAST) begin
            rsp_valid  <= 1'b1;
            rsp_err    <= 2'd3;
            rsp_data   <= 8'h00;
            peer_tx_en <= 1'b0;
            state      <= DONE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RX_FRAME: begin
          // Start bit is checked half a bit in; later bits a full bit apart.
          if (bit_cnt == 4'd0) begin
            if (cyc == HALF_LAST) begin
              cyc <= '0;
              if (rx_s2) state <= RX_WAIT;
              else bit_cnt <= 4'd1;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end else if (cyc == BIT_LAST) begin
            cyc     <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt <= 4'd8) begin
              sh <= {rx_s2, sh[7:1]};
            end else if (bit_cnt == 4'd9) begin
              rx_par <= rx_s2;
            end else begin
              peer_flag <= rx_good;
              if (rx_good) begin
                rsp_valid  <= 1'b1;
                rsp_err    <= 2'd0;
                rsp_data   <= sh;
                peer_tx_en <= 1'b0;
                state      <= DONE;
              end else if (retry == RMAX) begin
                rsp_valid  <= 1'b1;
                rsp_err    <= 2'd2;
                rsp_data   <= 8'h00;
                peer_tx_en <= 1'b0;
                state      <= DONE;
              end else begin
                retry <= retry + 1'b1;
                tmr   <= '0;
                state <= RX_WAIT;
              end
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          peer_flag <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed bench for uart_cmd_host acting as the calculator peer.
// Small bit/gap timing keeps every scenario short.
module tb_uart_cmd_host;
  localparam int BIT = 8;

  logic       clk = 1'b0;
  logic       res;
  logic       cmd_valid;
  logic [7:0] cmd_a, cmd_b, cmd_op;
  logic       cmd_ready;
  logic       tx_line;
  logic       peer_rx_rdy, peer_rx_ok;
  logic       rx_line;
  logic       peer_tx_en, peer_flag;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_err;

  int checks   = 0;
  int failures = 0;
  int rsp_cnt  = 0;
  int n_wait;
  int cnt0;

  uart_cmd_host #(
    .BIT_CYCLES(BIT), .GAP_CYCLES(4), .MAX_RETRY(3), .TIMEOUT_BITS(64)
  ) dut (
    .clk(clk), .res(res), .cmd_valid(cmd_valid), .cmd_a(cmd_a),
    .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .tx_line(tx_line), .peer_rx_rdy(peer_rx_rdy), .peer_rx_ok(peer_rx_ok),
    .rx_line(rx_line), .peer_tx_en(peer_tx_en), .peer_flag(peer_flag),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt++;

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [7:0] ta, tb, top);
    @(negedge clk);
    chk("rdy_idle", cmd_ready, 1'b1);
    cmd_a = ta; cmd_b = tb; cmd_op = top; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rdy_busy", cmd_ready, 1'b0);
  endtask

  // Capture one frame on tx_line at mid-bit, then give the verdict.
  task automatic tx_expect(input string tag, input logic [7:0] exp,
                           input logic ok);
    logic [7:0] d;
    logic p, s;
    int n;
    d = 8'h00; p = 1'b0; s = 1'b0; n = 0;
    @(negedge clk);
    while (tx_line !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start"}, tx_line, 1'b0);
    if (tx_line === 1'b0) begin
      repeat (BIT / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (BIT) @(negedge clk);
        d[k] = tx_line;
      end
      repeat (BIT) @(negedge clk);
      p = tx_line;
      repeat (BIT) @(negedge clk);
      s = tx_line;
      peer_rx_ok = ok;
      chk({tag, "_data"}, d, exp);
      chk({tag, "_par"}, p, ^exp);
      chk({tag, "_stop"}, s, 1'b1);
    end
  endtask

  task automatic wait_tx_en();
    int n;
    n = 0;
    while (peer_tx_en !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_en", peer_tx_en, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par);
    logic [10:0] fr;
    fr = {1'b1, par, d, 1'b0};
    wait_tx_en();
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      rx_line = fr[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rsp(input string tag, input logic [1:0] err,
                          input logic [7:0] data, output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_err"}, rsp_err, err);
    if (err == 2'd0) begin
      chk({tag, "_data"}, rsp_data, data);
      chk({tag, "_flag"}, peer_flag, 1'b1);
    end
    chk({tag, "_txen"}, peer_tx_en, 1'b0);
    @(negedge clk);
    chk({tag, "_pulse"}, rsp_valid, 1'b0);
    chk({tag, "_ready"}, cmd_ready, 1'b1);
    chk({tag, "_flag1"}, peer_flag, 1'b1);
  endtask

  initial begin
    res = 1'b1; cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_op = 8'h00; peer_rx_rdy = 1'b1; peer_rx_ok = 1'b1; rx_line = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_line, 1'b1);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_txen", peer_tx_en, 1'b0);
    chk("rst_flag", peer_flag, 1'b1);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_data", rsp_data, 8'h00);
    chk("rst_err", rsp_err, 2'd0);
    res = 1'b0;

    // 1: add, with the first frame held off by peer_rx_rdy
    peer_rx_rdy = 1'b0;
    issue(8'h05, 8'h03, 8'h0A);
    repeat (30) @(negedge clk);
    chk("t1_hold", tx_line, 1'b1);
    peer_rx_rdy = 1'b1;
    tx_expect("t1_a", 8'h05, 1'b1);
    tx_expect("t1_b", 8'h03, 1'b1);
    tx_expect("t1_op", 8'h0A, 1'b1);
    fork
      send_frame(8'h08, 1'b1);
      wait_rsp("t1", 2'd0, 8'h08, n_wait);
    join

    // 2: B rejected once and resent
    issue(8'h7F, 8'h01, 8'h0B);
    tx_expect("t2_a", 8'h7F, 1'b1);
    tx_expect("t2_b", 8'h01, 1'b0);
    tx_expect("t2_b2", 8'h01, 1'b1);
    tx_expect("t2_op", 8'h0B, 1'b1);
    fork
      send_frame(8'h7E, 1'b0);
      wait_rsp("t2", 2'd0, 8'h7E, n_wait);
    join

    // 3: bad result parity, then a good resend
    issue(8'h0E, 8'h0C, 8'h0C);
    tx_expect("t3_a", 8'h0E, 1'b1);
    tx_expect("t3_b", 8'h0C, 1'b1);
    tx_expect("t3_op", 8'h0C, 1'b1);
    cnt0 = rsp_cnt;
    send_frame(8'h0C, 1'b1);
    chk("t3_badflag", peer_flag, 1'b0);
    chk("t3_norsp", rsp_cnt, cnt0);
    fork
      send_frame(8'h0C, 1'b0);
      wait_rsp("t3", 2'd0, 8'h0C, n_wait);
    join

    // 4: no response -> timeout after 64 bit times in RX_WAIT
    issue(8'h01, 8'h02, 8'h0D);
    tx_expect("t4_a", 8'h01, 1'b1);
    tx_expect("t4_b", 8'h02, 1'b1);
    tx_expect("t4_op", 8'h0D, 1'b1);
    wait_rsp("t4", 2'd3, 8'h00, n_wait);
    chk("t4_time", (n_wait >= 516 && n_wait <= 524), 1'b1);

    // 5: short low glitch is not a frame
    issue(8'h20, 8'h10, 8'h0A);
    tx_expect("t5_a", 8'h20, 1'b1);
    tx_expect("t5_b", 8'h10, 1'b1);
    tx_expect("t5_op", 8'h0A, 1'b1);
    wait_tx_en();
    cnt0 = rsp_cnt;
    @(posedge clk);
    #1 rx_line = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_line = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5_norsp", rsp_cnt, cnt0);
    chk("t5_txen", peer_tx_en, 1'b1);
    fork
      send_frame(8'h30, 1'b0);
      wait_rsp("t5", 2'd0, 8'h30, n_wait);
    join

    // 6: reset in the middle of A's second data bit
    issue(8'h55, 8'h66, 8'h0A);
    n_wait = 0;
    while (tx_line !== 1'b0 && n_wait < 3000) begin
      @(negedge clk);
      n_wait++;
    end
    chk("t6_start", tx_line, 1'b0);
    repeat (20) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    chk("t6_tx", tx_line, 1'b1);
    chk("t6_ready", cmd_ready, 1'b1);
    chk("t6_txen", peer_tx_en, 1'b0);
    repeat (20) @(negedge clk);
    chk("t6_quiet", tx_line, 1'b1);
    issue(8'h0A, 8'h05, 8'h0D);
    tx_expect("t6_a", 8'h0A, 1'b1);
    tx_expect("t6_b", 8'h05, 1'b1);
    tx_expect("t6_op", 8'h0D, 1'b1);
    fork
      send_frame(8'h0F, 1'b0);
      wait_rsp("t6", 2'd0, 8'h0F, n_wait);
    join

    // 7: A rejected on every try -> TX retries exhausted
    issue(8'h81, 8'h00, 8'h0A);
    for (int i = 0; i < 4; i++) tx_expect("t7_a", 8'h81, 1'b0);
    wait_rsp("t7", 2'd1, 8'h00, n_wait);
    peer_rx_ok = 1'b1;

    // 8: every result frame bad -> RX retries exhausted
    issue(8'h01, 8'h01, 8'h0A);
    tx_expect("t8_a", 8'h01, 1'b1);
    tx_expect("t8_b", 8'h01, 1'b1);
    tx_expect("t8_op", 8'h0A, 1'b1);
    cnt0 = rsp_cnt;
    for (int i = 0; i < 3; i++) send_frame(8'h02, 1'b0);
    chk("t8_badflag", peer_flag, 1'b0);
    chk("t8_norsp", rsp_cnt, cnt0);
    fork
      send_frame(8'h02, 1'b0);
      wait_rsp("t8", 2'd2, 8'h00, n_wait);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
